// File: rtl/nios_project_led_driver.sv
// Purpose: PWM/blink LED driver for the NIOS LED PIO, with patterns double-buffered at PWM period boundaries.
// Latency: led_out lags the counter state by 1 cycle; new pattern/duty are shown the cycle after the next period boundary.
// Backpressure: none; the inputs are sampled levels. Optional blinking is enabled with macro LED_DRIVER_BLINK_EN.
module nios_project_led_driver #(
    parameter int NUM_LEDS      = 10,
    parameter int CLK_DIV       = 50000,
    parameter int BLINK_PERIODS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic [3:0]          duty,
    input  logic [NUM_LEDS-1:0] blink_mask,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                period_start
);

    localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0]       prescaler_q, prescaler_d;
    logic [3:0]          pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0] active_pattern_q, active_pattern_d;
    logic [3:0]          active_duty_q, active_duty_d;
    logic [NUM_LEDS-1:0] led_out_q, led_out_d;
    logic                period_start_q, period_start_d;
    logic                tick;
    logic                boundary;
    logic                lit;
    logic [NUM_LEDS-1:0] blink_off_mask;

`ifdef LED_DRIVER_BLINK_EN
    localparam int            BW        = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIODS - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    // Count period boundaries and flip the blink phase each time the count wraps.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (boundary) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Blink state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // The mask is taken live so software can start/stop blinking without waiting a period.
    assign blink_off_mask = blink_phase_q ? blink_mask : '0;
`else
    logic blink_mask_unused;

    // Blinking compiled out: the port remains for a stable interface but has no effect.
    assign blink_mask_unused = ^blink_mask;
    assign blink_off_mask    = '0;
`endif

    // Prescaler, PWM counter, period-boundary double buffering and output drive.
    always_comb begin
        tick             = (prescaler_q == PRE_MAX);
        boundary         = tick && (pwm_cnt_q == 4'hF);
        prescaler_d      = tick ? '0 : prescaler_q + PW'(1);
        pwm_cnt_d        = tick ? pwm_cnt_q + 4'd1 : pwm_cnt_q;
        active_pattern_d = boundary ? pattern_in : active_pattern_q;
        active_duty_d    = boundary ? duty : active_duty_q;
        period_start_d   = boundary;
        // Strict compare: duty 15 still leaves one dark tick, duty 0 is always dark.
        lit              = (pwm_cnt_q < active_duty_q);
        led_out_d        = active_pattern_q & {NUM_LEDS{lit}} & ~blink_off_mask;
    end

    // Core state registers; reset drops any pending pattern and restarts the period.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q      <= '0;
            pwm_cnt_q        <= '0;
            active_pattern_q <= '0;
            active_duty_q    <= '0;
            led_out_q        <= '0;
            period_start_q   <= 1'b0;
        end else begin
            prescaler_q      <= prescaler_d;
            pwm_cnt_q        <= pwm_cnt_d;
            active_pattern_q <= active_pattern_d;
            active_duty_q    <= active_duty_d;
            led_out_q        <= led_out_d;
            period_start_q   <= period_start_d;
        end
    end

    assign led_out      = led_out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_nios_project_led_driver.sv
// Purpose: directed test of nios_project_led_driver with CLK_DIV=2, BLINK_PERIODS=2, NUM_LEDS=10.
// Latency: a PWM period is 32 cycles; loads happen on the cycle numbered 32*n after reset release.
// Backpressure: none; inputs are changed 1 time unit after a rising edge.
module tb_nios_project_led_driver;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] pattern_in = '0;
    logic [3:0]   duty = '0;
    logic [N-1:0] blink_mask = '0;
    logic [N-1:0] led_out;
    logic         period_start;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    // expected state after the most recent edge
    logic [N-1:0] m_act;
    logic [3:0]   m_duty;
    logic         m_phase;
    int           m_bcnt;

    // activity counters over a window
    int hi0, hi1, nps, nz, diff;

    nios_project_led_driver #(
        .NUM_LEDS(N),
        .CLK_DIV(2),
        .BLINK_PERIODS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pattern_in(pattern_in),
        .duty(duty),
        .blink_mask(blink_mask),
        .led_out(led_out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at k=%0d: got=%h expected=%h", tag, k, got, exp);
        end
    endtask

    task automatic clr_model();
        k       = 0;
        m_act   = '0;
        m_duty  = '0;
        m_phase = 1'b0;
        m_bcnt  = 0;
    endtask

    task automatic zc();
        hi0 = 0; hi1 = 0; nps = 0; nz = 0; diff = 0;
    endtask

    // One clock edge: predict outputs from the expected state, then compare.
    task automatic step();
        logic [N-1:0] e_led;
        logic [N-1:0] off;
        logic [3:0]   pwm_prev;
        logic         e_ps;
        k++;
        pwm_prev = 4'(((k - 1) >> 1) & 15);
        off      = m_phase ? blink_mask : '0;
        e_led    = m_act & {N{pwm_prev < m_duty}} & ~off;
        e_ps     = (k % 32 == 0);
        if (k % 32 == 0) begin
            m_act  = pattern_in;
            m_duty = duty;
`ifdef LED_DRIVER_BLINK_EN
            m_bcnt++;
            if (m_bcnt == 2) begin
                m_bcnt  = 0;
                m_phase = ~m_phase;
            end
`endif
        end
        @(posedge clk);
        #1;
        check("led_out", 32'(led_out), 32'(e_led));
        check("period_start", 32'(period_start), 32'(e_ps));
        if (led_out[0]) hi0++;
        if (led_out[1]) hi1++;
        if (period_start) nps++;
        if (led_out != '0) nz++;
        if (led_out[0] != led_out[1]) diff++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_led_out", 32'(led_out), 32'h0);
            check("rst_period_start", 32'(period_start), 32'h0);
        end
        reset = 1'b0;
        clr_model();
    endtask

    initial begin
        // basic PWM at duty 8
        pattern_in = 10'h3FF;
        duty       = 4'd8;
        blink_mask = '0;
        do_reset(3);
        zc();
        run(32);
        check("first32_dark", 32'(nz), 32'd0);
        check("first32_ps", 32'(nps), 32'd1);
        zc();
        run(64);
        check("duty8_on_cycles", 32'(hi0), 32'd32);
        check("duty8_ps_count", 32'(nps), 32'd2);

        // pattern change mid-period is held off until the next boundary
        run(4);
        pattern_in = 10'h001;
        zc();
        run(28);
        check("hold_old_bit1", 32'(hi1), 32'd12);
        zc();
        run(32);
        check("new_bit1_dark", 32'(hi1), 32'd0);
        check("new_bit0_on", 32'(hi0), 32'd16);

        // duty 0 then duty 15
        pattern_in = 10'h3FF;
        duty       = 4'd0;
        run(32);
        zc();
        run(8);
        duty = 4'd15;
        run(24);
        check("duty0_dark", 32'(nz), 32'd0);
        zc();
        run(32);
        check("duty15_bit0", 32'(hi0), 32'd30);
        check("duty15_bit1", 32'(hi1), 32'd30);

        // reset in the middle of a lit period
        run(10);
        check("pre_reset_lit", 32'(led_out), 32'h3FF);
        do_reset(1);
        zc();
        run(31);
        check("post_reset_no_ps", 32'(nps), 32'd0);
        check("post_reset_dark", 32'(nz), 32'd0);
        run(1);
        check("post_reset_ps_at_32", 32'(period_start), 32'd1);
        run(8);

        // blink stimulus
        pattern_in = 10'h003;
        duty       = 4'd15;
        blink_mask = 10'h002;
        do_reset(2);
        run(32);
        zc();
        run(128);
        check("blink_bit0_on", 32'(hi0), 32'd120);
`ifdef LED_DRIVER_BLINK_EN
        check("blink_bit1_on", 32'(hi1), 32'd60);
`else
        check("noblink_bits_equal", 32'(diff), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_project_led_driver.md
NIOS_PROJECT_LED_DRIVER -- requirements
Module: nios_project_led_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 10: LED count and width of the pattern, mask and output vectors.
REQ-002 SHALL have parameter CLK_DIV, default 50000: clk cycles per PWM tick; legal range 2..2^20.
REQ-003 SHALL have parameter BLINK_PERIODS, default 64: PWM periods per blink half-cycle; legal range 1..1024.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pattern_in, input, NUM_LEDS bits: LED on/off pattern, driven by the LED PIO out_port.
REQ-007 SHALL have port duty, input, 4 bits: brightness; an LED is lit for duty out of 16 ticks per period.
REQ-008 SHALL have port blink_mask, input, NUM_LEDS bits: 1 selects blinking for that LED.
REQ-009 SHALL have port led_out, output, NUM_LEDS bits: registered drive to the board LEDs.
REQ-010 SHALL have port period_start, output, 1 bit: one-cycle pulse marking the start of each PWM period.

Function
REQ-011 SHALL run a prescaler that counts 0..CLK_DIV-1 and wraps to 0; tick is 1 in the cycle where prescaler == CLK_DIV-1.
REQ-012 SHALL run a 4-bit pwm_cnt that advances only on tick and wraps 15->0.
REQ-013 SHALL define a boundary as tick && pwm_cnt == 15.
REQ-014 SHALL, at a boundary, load active_pattern <= pattern_in and active_duty <= duty.
REQ-015 SHALL ignore changes on pattern_in and duty between boundaries (glitch-free double buffering).
REQ-016 SHALL register period_start high for exactly the one cycle after each boundary.
REQ-017 SHALL register led_out every cycle as active_pattern & {NUM_LEDS{pwm_cnt < active_duty}} & ~blink_off_mask.
  - led_out therefore lags counter state by 1 cycle.
REQ-018 SHALL give duty 0 -> LED always off; duty 15 -> LED on 15/16 of ticks; no value gives 100% on.
REQ-019 SHALL force blink_off_mask to all zeros whenever blinking is compiled out or blink_phase == 0.
REQ-020 SHALL NOT expose any intermediate state combinationally on an output; all outputs are flops.

Reset
REQ-021 SHALL, while reset is high at a clk edge, clear prescaler, pwm_cnt, active_pattern, active_duty, blink counter, blink_phase, led_out and period_start to 0.
REQ-022 SHALL take effect mid-period and discard any pending pattern.
  - The first load after release occurs at the first boundary: CLK_DIV*16 cycles after release.
  - led_out stays 0 until that load.

Configuration
REQ-023 SHALL, when macro LED_DRIVER_BLINK_EN is defined, add a blink counter that counts boundaries 0..BLINK_PERIODS-1 and toggles blink_phase on wrap.
  - blink_off_mask = blink_mask when blink_phase == 1.
  - blink_mask is sampled live, not double-buffered.
REQ-024 SHALL, when LED_DRIVER_BLINK_EN is undefined, omit the blink counter and blink_phase logic.
  - blink_mask stays a port but is ignored.
  - led_out depends only on pattern and duty.

Verification (CLK_DIV=2, BLINK_PERIODS=2, NUM_LEDS=10)
REQ-025 SHALL cover: reset, pattern_in=0x3FF, duty=8 -> led_out=0 for the first 32 cycles, then 0x3FF for 16 cycles / 0x000 for 16 cycles, repeating; period_start pulses every 32 cycles.
REQ-026 SHALL cover: pattern_in changed 0x3FF->0x001 mid-period -> led_out unchanged until the next period_start, then only bit 0 toggles.
REQ-027 SHALL cover: duty=0 then duty=15 -> led_out all-zero for a full period; then high for 30 of 32 cycles per period.
REQ-028 SHALL cover: reset asserted mid-period with led_out=0x3FF -> led_out=0 the next cycle; the next period_start comes 32 cycles after release.
REQ-029 SHALL cover, with LED_DRIVER_BLINK_EN: blink_mask=0x002, pattern=0x003, duty=15 -> bit 1 is dark for 2 of every 4 periods; bit 0 is unaffected.
REQ-030 SHALL cover, without LED_DRIVER_BLINK_EN: the same stimulus as REQ-029 -> bits 0 and 1 are identical every cycle.
